// File: rtl/bcd_counter_3digit.sv
// Three-decade BCD counter (000-999) with tick prescaler, synchronous clear and parallel load.
// Optional macro BCD_DOWN_COUNT_EN enables Up_Down-controlled down counting with borrow.
module bcd_counter_3digit #(
   parameter int TICK_DIV = 100
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        Clear,
   input  logic        Load,
   input  logic [11:0] Load_Value,
   input  logic        Up_Down,
   output logic [3:0]  Ones_Out,
   output logic [3:0]  Tens_Out,
   output logic [3:0]  Hundreds_Out,
   output logic        Tick_Out,
   output logic        Wrap_Out
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [3:0]    ones_q, ones_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    hund_q, hund_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

`ifndef BCD_DOWN_COUNT_EN
   logic unused_up_down;
   assign unused_up_down = Up_Down;
`endif

   function automatic logic [3:0] clamp9(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   always_comb begin
      div_cnt_d = div_cnt_q;
      ones_d    = ones_q;
      tens_d    = tens_q;
      hund_d    = hund_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;
      if (Clear) begin
         div_cnt_d = '0;
         ones_d    = 4'd0;
         tens_d    = 4'd0;
         hund_d    = 4'd0;
      end else if (Load) begin
         div_cnt_d = '0;
         ones_d    = clamp9(Load_Value[3:0]);
         tens_d    = clamp9(Load_Value[7:4]);
         hund_d    = clamp9(Load_Value[11:8]);
      end else if (Enable) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
`ifdef BCD_DOWN_COUNT_EN
            if (!Up_Down) begin
               // Borrow ripples while the lower digit underflows from 0 to 9.
               if (ones_q == 4'd0) begin
                  ones_d = 4'd9;
                  if (tens_q == 4'd0) begin
                     tens_d = 4'd9;
                     if (hund_q == 4'd0) begin
                        hund_d = 4'd9;
                        wrap_d = 1'b1;
                     end else begin
                        hund_d = hund_q - 4'd1;
                     end
                  end else begin
                     tens_d = tens_q - 4'd1;
                  end
               end else begin
                  ones_d = ones_q - 4'd1;
               end
            end else
`endif
            begin
               if (ones_q == 4'd9) begin
                  ones_d = 4'd0;
                  if (tens_q == 4'd9) begin
                     tens_d = 4'd0;
                     if (hund_q == 4'd9) begin
                        hund_d = 4'd0;
                        wrap_d = 1'b1;
                     end else begin
                        hund_d = hund_q + 4'd1;
                     end
                  end else begin
                     tens_d = tens_q + 4'd1;
                  end
               end else begin
                  ones_d = ones_q + 4'd1;
               end
            end
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_cnt_q <= '0;
         ones_q    <= 4'd0;
         tens_q    <= 4'd0;
         hund_q    <= 4'd0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         ones_q    <= ones_d;
         tens_q    <= tens_d;
         hund_q    <= hund_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
      end
   end

   assign Ones_Out     = ones_q;
   assign Tens_Out     = tens_q;
   assign Hundreds_Out = hund_q;
   assign Tick_Out     = tick_q;
   assign Wrap_Out     = wrap_q;

endmodule
